// File: rtl/board_input_conditioner.sv
// Pin-side conditioning for the PIO input ports: resynchronise, debounce and
// zero-extend the push-buttons and slide switches, plus local event pulses.

module debounce_bank #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic [W-1:0] changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     s1;
  logic [W-1:0]     s2;
  logic [W-1:0]     mismatch;
  logic [W-1:0]     accept;
  logic [CNT_W-1:0] cnt [W];

  // A bit is accepted on the edge that would be its DEBOUNCE_CYCLES-th
  // consecutive mismatch, so the counter never needs to wrap.
  always_comb begin
    mismatch = s2 ^ stable;
    accept   = '0;
    for (int i = 0; i < W; i++) begin
      accept[i] = mismatch[i] && (cnt[i] == LAST);
    end
  end

  // NOTE: every register here uses <= so all bits sample pre-edge values;
  // the counter array is reset too, so a partial count never survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      stable  <= '0;
      changed <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= din;
      s2      <= s1;
      stable  <= stable ^ accept;
      changed <= accept;
      for (int i = 0; i < W; i++) begin
        if (accept[i] || !mismatch[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

module board_input_conditioner #(
  parameter int NBTN            = 4,
  parameter int NSW             = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] key_raw,
  input  logic [NSW-1:0]  sw_raw,
  output logic [31:0]     buttons_export,
  output logic [31:0]     switchs_export,
  output logic [NBTN-1:0] btn_press,
  output logic            sw_change
);

  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_stable;
  logic [NBTN-1:0] btn_changed;
  logic [NSW-1:0]  sw_stable;
  logic [NSW-1:0]  sw_changed;

  // Buttons are normalised to pressed=1 before they reach the synchroniser.
  assign btn_level = (BTN_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  debounce_bank #(
    .W               (NBTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .din     (btn_level),
    .stable  (btn_stable),
    .changed (btn_changed)
  );

  debounce_bank #(
    .W               (NSW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw (
    .clk     (clk),
    .reset   (reset),
    .din     (sw_raw),
    .stable  (sw_stable),
    .changed (sw_changed)
  );

  // A bit that just changed and now reads 1 is a released->pressed edge.
  assign buttons_export = 32'(btn_stable);
  assign switchs_export = 32'(sw_stable);
  assign btn_press      = btn_changed & btn_stable;
  assign sw_change      = |sw_changed;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner: a window-based model of the
// debounce rules checked every cycle, plus directed literal expectations.

module tb_board_input_conditioner;

  localparam int NB = 4;
  localparam int NS = 18;
  localparam int D  = 4;
  localparam int NT = NB + NS;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] key_raw;
  logic [NS-1:0] sw_raw;
  logic [31:0]   buttons_export;
  logic [31:0]   switchs_export;
  logic [NB-1:0] btn_press;
  logic          sw_change;

  int n_checks = 0;
  int n_errors = 0;

  board_input_conditioner #(
    .NBTN            (NB),
    .NSW             (NS),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16),
    .BTN_ACTIVE_LOW  (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_raw        (key_raw),
    .sw_raw         (sw_raw),
    .buttons_export (buttons_export),
    .switchs_export (switchs_export),
    .btn_press      (btn_press),
    .sw_change      (sw_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Model: each pin is seen two edges late; a level is accepted once the last
  // D seen samples all disagree with the accepted level.
  logic [NT-1:0] m_p1, m_p2, m_st, m_ev;
  logic [D-1:0]  win [NT];
  bit            started = 1'b0;

  always @(posedge clk) begin
    logic [NT-1:0] pins;
    pins = {sw_raw, ~key_raw};
    if (reset) begin
      m_p1 = '0;
      m_p2 = '0;
      m_st = '0;
      m_ev = '0;
      for (int i = 0; i < NT; i++) win[i] = '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        win[i] = {win[i][D-2:0], m_p2[i]};
        m_ev[i] = 1'b0;
        if (win[i] == {D{~m_st[i]}}) begin
          m_st[i] = ~m_st[i];
          m_ev[i] = 1'b1;
        end
      end
      m_p2 = m_p1;
      m_p1 = pins;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("buttons_export", buttons_export, 32'(m_st[NB-1:0]));
      check("switchs_export", switchs_export, 32'(m_st[NT-1:NB]));
      check("btn_press", 32'(btn_press), 32'(m_ev[NB-1:0] & m_st[NB-1:0]));
      check("sw_change", 32'(sw_change), 32'(|m_ev[NT-1:NB]));
    end
  end

  task automatic edge_then_sample(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;
    sw_raw  = '0;

    // Reset held 3 cycles with all buttons released.
    edge_then_sample(1);
    check("reset_buttons", buttons_export, 32'h0);
    check("reset_press", 32'(btn_press), 32'h0);
    edge_then_sample(2);
    @(negedge clk);
    reset = 1'b0;
    edge_then_sample(3);
    check("post_reset_buttons", buttons_export, 32'h0);
    check("post_reset_switchs", switchs_export, 32'h0);
    check("post_reset_sw_change", 32'(sw_change), 32'h0);

    // Button 0 press then release: 5-edge latency, pulse only on press.
    @(negedge clk);
    key_raw = 4'hE;
    edge_then_sample(5);
    check("press_k4_export", buttons_export, 32'h0);
    edge_then_sample(1);
    check("press_k5_export", buttons_export, 32'h1);
    check("press_k5_pulse", 32'(btn_press), 32'h1);
    edge_then_sample(1);
    check("press_k6_pulse", 32'(btn_press), 32'h0);
    check("press_k6_export", buttons_export, 32'h1);
    @(negedge clk);
    key_raw = 4'hF;
    edge_then_sample(5);
    check("release_k4_export", buttons_export, 32'h1);
    edge_then_sample(1);
    check("release_k5_export", buttons_export, 32'h0);
    check("release_k5_pulse", 32'(btn_press), 32'h0);

    // Glitch on button 1: 3 low, 1 high, 3 low never reaches 4 in a row.
    @(negedge clk);
    key_raw = 4'hD;
    repeat (3) @(negedge clk);
    key_raw = 4'hF;
    @(negedge clk);
    key_raw = 4'hD;
    repeat (3) @(negedge clk);
    key_raw = 4'hF;
    for (int i = 0; i < 8; i++) begin
      edge_then_sample(1);
      check("glitch_export", buttons_export, 32'h0);
      check("glitch_pulse", 32'(btn_press), 32'h0);
    end

    // All switches to 1 at once: one export update and a single pulse.
    @(negedge clk);
    sw_raw = 18'h3FFFF;
    edge_then_sample(5);
    check("sw_k4_export", switchs_export, 32'h0);
    check("sw_k4_change", 32'(sw_change), 32'h0);
    edge_then_sample(1);
    check("sw_k5_export", switchs_export, 32'h0003FFFF);
    check("sw_k5_change", 32'(sw_change), 32'h1);
    edge_then_sample(1);
    check("sw_k6_change", 32'(sw_change), 32'h0);

    // Button 3 held across reset: reported as a fresh press after release.
    @(negedge clk);
    reset   = 1'b1;
    key_raw = 4'h7;
    repeat (3) @(negedge clk);
    check("rst_hold_export", buttons_export, 32'h0);
    check("rst_hold_switchs", switchs_export, 32'h0);
    reset = 1'b0;
    edge_then_sample(5);
    check("held_f4_export", buttons_export, 32'h0);
    edge_then_sample(1);
    check("held_f5_export", buttons_export, 32'h8);
    check("held_f5_pulse", 32'(btn_press), 32'h8);
    check("held_f5_sw_change", 32'(sw_change), 32'h1);
    @(negedge clk);
    key_raw = 4'hF;
    sw_raw  = '0;
    repeat (10) @(negedge clk);

    // Button 0 pressed, reset for one edge at count 2: count restarts.
    key_raw = 4'hE;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    edge_then_sample(5);
    check("midrst_f4_export", buttons_export, 32'h0);
    edge_then_sample(1);
    check("midrst_f5_export", buttons_export, 32'h1);
    check("midrst_f5_pulse", 32'(btn_press), 32'h1);
    @(negedge clk);
    key_raw = 4'hF;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
